// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the three-port SDRAM command-port arbiter.
package sdram_arb_pkg;

    localparam int NUM_PORTS = 3;

    typedef logic [1:0] port_idx_t;

    localparam port_idx_t PORT_VGA = 2'd0;
    localparam port_idx_t PORT_CPU = 2'd1;
    localparam port_idx_t PORT_AUX = 2'd2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RESPOND = 2'd2
    } state_t;

    // One-hot ack vector for a granted port index; index 3 never occurs.
    function automatic logic [NUM_PORTS-1:0] port_onehot(input port_idx_t idx);
        logic [NUM_PORTS-1:0] oh;
        oh = '0;
        case (idx)
            PORT_VGA: oh = 3'b001;
            PORT_CPU: oh = 3'b010;
            PORT_AUX: oh = 3'b100;
            default:  oh = '0;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/sdram_arb_select.sv
// Combinational winner selection: port 0 fixed priority with starvation guard,
// ports 1 and 2 round-robin.
module sdram_arb_select
    import sdram_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 8,
    parameter int CNT_W        = $clog2(STARVE_LIMIT + 1)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [CNT_W-1:0]     starve_cnt,
    input  port_idx_t            rr_last,
    output port_idx_t            grant,
    output logic                 grant_valid
);

    logic others;
    logic starved;

    always_comb begin
        others      = req[PORT_CPU] | req[PORT_AUX];
        starved     = int'(starve_cnt) >= STARVE_LIMIT;
        grant_valid = |req;
        grant       = PORT_VGA;
        if (req[PORT_VGA] && (!starved || !others)) begin
            grant = PORT_VGA;
        end else if (rr_last == PORT_CPU) begin
            // Port 2 is next in turn; fall back to port 1 if it is idle.
            grant = req[PORT_AUX] ? PORT_AUX : PORT_CPU;
        end else begin
            grant = req[PORT_CPU] ? PORT_CPU : PORT_AUX;
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares the SDRAM controller command port between VGA DMA, CPU and aux DMA;
// one single-word transaction outstanding at a time.
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH   = 24,
    parameter int DATA_WIDTH   = 16,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  clk,
    input  logic                  reset_in,

    input  logic                  p0_req,
    input  logic                  p0_wr,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic [DATA_WIDTH-1:0] p0_wdata,
    input  logic [1:0]            p0_bytesel,
    output logic                  p0_ack,

    input  logic                  p1_req,
    input  logic                  p1_wr,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [DATA_WIDTH-1:0] p1_wdata,
    input  logic [1:0]            p1_bytesel,
    output logic                  p1_ack,

    input  logic                  p2_req,
    input  logic                  p2_wr,
    input  logic [ADDR_WIDTH-1:0] p2_addr,
    input  logic [DATA_WIDTH-1:0] p2_wdata,
    input  logic [1:0]            p2_bytesel,
    output logic                  p2_ack,

    output logic [DATA_WIDTH-1:0] rdata,

    output logic                  mem_req,
    output logic                  mem_wr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [1:0]            mem_bytesel,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    state_t               state;
    state_t               next_state;
    port_idx_t            g;
    port_idx_t            rr_last;
    logic [CNT_W-1:0]     starve_cnt;
    logic [NUM_PORTS-1:0] ack;

    logic [NUM_PORTS-1:0] req;
    port_idx_t            grant;
    logic                 grant_valid;
    logic                 others;

    logic                  sel_wr;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [1:0]            sel_bytesel;

    assign req    = {p2_req, p1_req, p0_req};
    assign others = p1_req | p2_req;

    sdram_arb_select #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .CNT_W        (CNT_W)
    ) u_select (
        .req         (req),
        .starve_cnt  (starve_cnt),
        .rr_last     (rr_last),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    always_comb begin
        sel_wr      = p0_wr;
        sel_addr    = p0_addr;
        sel_wdata   = p0_wdata;
        sel_bytesel = p0_bytesel;
        case (grant)
            PORT_CPU: begin
                sel_wr      = p1_wr;
                sel_addr    = p1_addr;
                sel_wdata   = p1_wdata;
                sel_bytesel = p1_bytesel;
            end
            PORT_AUX: begin
                sel_wr      = p2_wr;
                sel_addr    = p2_addr;
                sel_wdata   = p2_wdata;
                sel_bytesel = p2_bytesel;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_in) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (grant_valid) next_state = ISSUE;
            ISSUE:   if (mem_ack)     next_state = RESPOND;
            RESPOND: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_in) begin
            g           <= PORT_VGA;
            rr_last     <= PORT_AUX;
            starve_cnt  <= '0;
            ack         <= '0;
            rdata       <= '0;
            mem_req     <= 1'b0;
            mem_wr      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_bytesel <= '0;
        end else begin
            ack <= '0;
            if (state == IDLE && grant_valid) begin
                g           <= grant;
                mem_req     <= 1'b1;
                mem_wr      <= sel_wr;
                mem_addr    <= sel_addr;
                mem_wdata   <= sel_wdata;
                mem_bytesel <= sel_bytesel;
                // Count port-0 wins only while someone else is waiting.
                if (grant == PORT_VGA) begin
                    if (others) begin
                        if (starve_cnt != CNT_W'(STARVE_LIMIT)) begin
                            starve_cnt <= starve_cnt + CNT_W'(1);
                        end
                    end else begin
                        starve_cnt <= '0;
                    end
                end else begin
                    starve_cnt <= '0;
                    rr_last    <= grant;
                end
            end
            if (state == ISSUE && mem_ack) begin
                mem_req <= 1'b0;
                ack     <= port_onehot(g);
                if (!mem_wr) begin
                    rdata <= mem_rdata;
                end
            end
        end
    end

    assign p0_ack = ack[PORT_VGA];
    assign p1_ack = ack[PORT_CPU];
    assign p2_ack = ack[PORT_AUX];

endmodule
